// File: rtl/clock_pkg.sv
// clock_pkg: shared state encoding, BCD limits and BCD increment helpers for the clock set controller
package clock_pkg;
  typedef enum logic [1:0] {
    RUN     = 2'd0,
    SET_HR  = 2'd1,
    SET_MIN = 2'd2,
    COMMIT  = 2'd3
  } state_t;
  localparam logic [3:0] HR_MAX_TENS      = 4'd2;
  localparam logic [3:0] HR_MAX_ONES_AT_2 = 4'd3;
  localparam logic [3:0] MIN_MAX_TENS     = 4'd5;
  localparam logic [3:0] BCD_MAX          = 4'd9;
  function automatic logic [7:0] hr_inc(input logic [7:0] h);
    return (h[7:4] == HR_MAX_TENS && h[3:0] == HR_MAX_ONES_AT_2) ? 8'h00 :
           (h[3:0] == BCD_MAX) ? {h[7:4] + 4'd1, 4'd0} : {h[7:4], h[3:0] + 4'd1};
  endfunction
  function automatic logic [7:0] min_inc(input logic [7:0] m);
    return (m[3:0] != BCD_MAX) ? {m[7:4], m[3:0] + 4'd1} :
           (m[7:4] == MIN_MAX_TENS) ? 8'h00 : {m[7:4] + 4'd1, 4'd0};
  endfunction
endpackage

// File: rtl/btn_event.sv
// btn_event: rising-edge detect with optional hold-to-repeat for a clean button level
module btn_event #(
  parameter bit REPEAT_EN  = 1'b0,
  parameter int REPEAT_DLY = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic ev
);
  localparam int CW = REPEAT_DLY > 1 ? $clog2(REPEAT_DLY) : 1;
  logic          prev;
  logic          armed;
  logic [CW-1:0] cnt;
  assign ev = btn & armed & (~prev | (REPEAT_EN & (cnt == CW'(REPEAT_DLY - 1))));
  // button history; armed stays low until the button is seen released, so a press held through reset is ignored
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      prev  <= 1'b0;
      armed <= 1'b0;
      cnt   <= '0;
    end else begin
      prev  <= btn;
      armed <= armed | ~btn;
      cnt   <= (!btn || cnt == CW'(REPEAT_DLY - 1)) ? '0 : cnt + 1'b1;
    end
endmodule

// File: rtl/clock_set_controller.sv
// clock_set_controller: 1 s tick generation and button-driven hour/minute set sequencing for the clock counter
module clock_set_controller
  import clock_pkg::*;
#(
  parameter int TICK_DIV   = 10,
  parameter int BLINK_DIV  = 5,
  parameter int REPEAT_DLY = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic [3:0] cur_hr_tens,
  input  logic [3:0] cur_hr_ones,
  input  logic [3:0] cur_min_tens,
  input  logic [3:0] cur_min_ones,
  output logic       tick_en,
  output logic       load,
  output logic [3:0] ld_hr_tens,
  output logic [3:0] ld_hr_ones,
  output logic [3:0] ld_min_tens,
  output logic [3:0] ld_min_ones,
  output logic       blank_hr,
  output logic       blank_min,
  output logic [1:0] mode
);
  localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam int BW = BLINK_DIV > 1 ? $clog2(BLINK_DIV) : 1;
  state_t        state, state_n;
  logic          mev, iev;
  logic [PW-1:0] presc, presc_n;
  logic [BW-1:0] bcnt, bcnt_n;
  logic          phase, phase_n;
  logic [7:0]    sh_hr, sh_hr_n, sh_min, sh_min_n;
  logic          set_n, bclr, bwrap;
  btn_event #(.REPEAT_EN(1'b0), .REPEAT_DLY(REPEAT_DLY)) u_mode (
    .clk(clk), .rst(rst), .btn(btn_mode), .ev(mev)
  );
  btn_event #(.REPEAT_EN(1'b1), .REPEAT_DLY(REPEAT_DLY)) u_inc (
    .clk(clk), .rst(rst), .btn(btn_inc), .ev(iev)
  );
  assign mode = state;
  // next state, shadow edits, prescaler and blink timing; a mode event always beats a same-cycle inc
  always_comb begin
    state_n  = state;
    sh_hr_n  = sh_hr;
    sh_min_n = sh_min;
    case (state)
      RUN: if (mev) begin
        state_n  = SET_HR;
        sh_hr_n  = {cur_hr_tens, cur_hr_ones};
        sh_min_n = {cur_min_tens, cur_min_ones};
      end
      SET_HR:  if (mev) state_n = SET_MIN; else if (iev) sh_hr_n = hr_inc(sh_hr);
      SET_MIN: if (mev) state_n = COMMIT; else if (iev) sh_min_n = min_inc(sh_min);
      default: state_n = RUN;
    endcase
    presc_n = (state_n != RUN || presc == PW'(TICK_DIV - 1)) ? '0 : presc + 1'b1;
    set_n   = state_n == SET_HR || state_n == SET_MIN;
    bclr    = !set_n || state_n != state || iev;
    bwrap   = bcnt == BW'(BLINK_DIV - 1);
    bcnt_n  = (bclr || bwrap) ? '0 : bcnt + 1'b1;
    phase_n = bclr ? 1'b0 : phase ^ bwrap;
  end
  // state and registered outputs; ld_* only change on the commit cycle
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state     <= RUN;
      presc     <= '0;
      bcnt      <= '0;
      phase     <= 1'b0;
      sh_hr     <= '0;
      sh_min    <= '0;
      tick_en   <= 1'b0;
      load      <= 1'b0;
      blank_hr  <= 1'b0;
      blank_min <= 1'b0;
      {ld_hr_tens, ld_hr_ones, ld_min_tens, ld_min_ones} <= '0;
    end else begin
      state     <= state_n;
      presc     <= presc_n;
      bcnt      <= bcnt_n;
      phase     <= phase_n;
      sh_hr     <= sh_hr_n;
      sh_min    <= sh_min_n;
      tick_en   <= state == RUN && state_n == RUN && presc == PW'(TICK_DIV - 1);
      load      <= state_n == COMMIT;
      blank_hr  <= state_n == SET_HR && phase_n;
      blank_min <= state_n == SET_MIN && phase_n;
      if (state_n == COMMIT) {ld_hr_tens, ld_hr_ones, ld_min_tens, ld_min_ones} <= {sh_hr_n, sh_min_n};
    end
endmodule

// File: tb/tb_clock_set_controller.sv
// tb_clock_set_controller: directed checks with a load-value scoreboard for clock_set_controller
module tb_clock_set_controller;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       btn_mode = 1'b0;
  logic       btn_inc = 1'b0;
  logic [3:0] cur_hr_tens = 4'd1, cur_hr_ones = 4'd2, cur_min_tens = 4'd3, cur_min_ones = 4'd4;
  logic       tick_en, load, blank_hr, blank_min;
  logic [3:0] ld_hr_tens, ld_hr_ones, ld_min_tens, ld_min_ones;
  logic [1:0] mode;
  int         vectors = 0;
  int         miscompares = 0;
  logic [15:0] exp_q[$];
  logic [15:0] exp_ld;

  clock_set_controller #(.TICK_DIV(10), .BLINK_DIV(5), .REPEAT_DLY(8)) dut (
    .clk(clk), .rst(rst), .btn_mode(btn_mode), .btn_inc(btn_inc),
    .cur_hr_tens(cur_hr_tens), .cur_hr_ones(cur_hr_ones),
    .cur_min_tens(cur_min_tens), .cur_min_ones(cur_min_ones),
    .tick_en(tick_en), .load(load),
    .ld_hr_tens(ld_hr_tens), .ld_hr_ones(ld_hr_ones),
    .ld_min_tens(ld_min_tens), .ld_min_ones(ld_min_ones),
    .blank_hr(blank_hr), .blank_min(blank_min), .mode(mode)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // scoreboard consumer: every load pulse must match the oldest expected load value
  always @(negedge clk) if (load === 1'b1) begin
    if (exp_q.size() == 0) chk("unexpected_load", {16'h0, ld_hr_tens, ld_hr_ones, ld_min_tens, ld_min_ones}, 32'hdead);
    else begin
      exp_ld = exp_q.pop_front();
      chk("ld_value", {16'h0, ld_hr_tens, ld_hr_ones, ld_min_tens, ld_min_ones}, {16'h0, exp_ld});
    end
  end

  task automatic pulse_mode();
    btn_mode = 1'b1;
    @(negedge clk);
    btn_mode = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_inc();
    btn_inc = 1'b1;
    @(negedge clk);
    btn_inc = 1'b0;
    @(negedge clk);
  endtask

  task automatic set_cur(input logic [15:0] t);
    {cur_hr_tens, cur_hr_ones, cur_min_tens, cur_min_ones} = t;
  endtask

  task automatic commit(input logic [15:0] exp);
    btn_mode = 1'b1;
    exp_q.push_back(exp);
    @(negedge clk);
    chk("commit_mode", 32'(mode), 32'd3);
    chk("commit_load", 32'(load), 32'd1);
    btn_mode = 1'b0;
    @(negedge clk);
    chk("post_commit_mode", 32'(mode), 32'd0);
    chk("post_commit_load", 32'(load), 32'd0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_tick", 32'(tick_en), 32'd0);
    chk("rst_load", 32'(load), 32'd0);
    chk("rst_mode", 32'(mode), 32'd0);
    chk("rst_blank", {30'h0, blank_hr, blank_min}, 32'd0);
    chk("rst_ld", {16'h0, ld_hr_tens, ld_hr_ones, ld_min_tens, ld_min_ones}, 32'd0);
    rst = 1'b1;
    for (int k = 1; k <= 50; k++) begin
      @(negedge clk);
      chk("run_tick", 32'(tick_en), 32'(k % 10 == 0));
    end
    chk("run_mode", 32'(mode), 32'd0);
    chk("run_load", 32'(load), 32'd0);
    pulse_mode();
    chk("enter_set_hr", 32'(mode), 32'd1);
    repeat (3) pulse_inc();
    chk("set_hr_tick", 32'(tick_en), 32'd0);
    pulse_mode();
    chk("enter_set_min", 32'(mode), 32'd2);
    btn_mode = 1'b1;
    exp_q.push_back(16'h1534);
    @(negedge clk);
    chk("commit_mode", 32'(mode), 32'd3);
    chk("commit_load", 32'(load), 32'd1);
    btn_mode = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      chk("tick_after_load", 32'(tick_en), 32'(k == 10));
      if (k == 1) chk("load_one_cycle", 32'(load), 32'd0);
    end
    set_cur(16'h2359);
    pulse_mode();
    pulse_inc();
    pulse_mode();
    pulse_inc();
    commit(16'h0000);
    set_cur(16'h0909);
    pulse_mode();
    pulse_inc();
    pulse_mode();
    pulse_inc();
    commit(16'h1010);
    set_cur(16'h1919);
    pulse_mode();
    pulse_inc();
    pulse_mode();
    pulse_inc();
    commit(16'h2020);
    set_cur(16'h0700);
    pulse_mode();
    pulse_mode();
    btn_inc = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      chk("hold_tick", 32'(tick_en), 32'd0);
    end
    btn_inc = 1'b0;
    commit(16'h0704);
    set_cur(16'h1122);
    btn_mode = 1'b1;
    @(negedge clk);
    chk("blink_entry_mode", 32'(mode), 32'd1);
    chk("blink_entry_blank", 32'(blank_hr), 32'd0);
    btn_mode = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      chk("blank_hr", 32'(blank_hr), 32'((k / 5) % 2));
      chk("blank_min_in_hr", 32'(blank_min), 32'd0);
    end
    btn_inc = 1'b1;
    @(negedge clk);
    chk("inc_clears_blink", 32'(blank_hr), 32'd0);
    btn_inc = 1'b0;
    @(negedge clk);
    btn_mode = 1'b1;
    btn_inc = 1'b1;
    @(negedge clk);
    chk("simul_mode_wins", 32'(mode), 32'd2);
    btn_mode = 1'b0;
    btn_inc = 1'b0;
    @(negedge clk);
    commit(16'h1222);
    set_cur(16'h0505);
    pulse_mode();
    pulse_mode();
    pulse_inc();
    rst = 1'b0;
    #1;
    chk("async_rst_mode", 32'(mode), 32'd0);
    chk("async_rst_ld", {16'h0, ld_hr_tens, ld_hr_ones, ld_min_tens, ld_min_ones}, 32'd0);
    chk("async_rst_flags", {29'h0, tick_en, load, blank_min}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    for (int k = 1; k <= 25; k++) begin
      @(negedge clk);
      chk("resume_tick", 32'(tick_en), 32'(k % 10 == 0));
    end
    chk("resume_mode", 32'(mode), 32'd0);
    chk("resume_ld", {16'h0, ld_hr_tens, ld_hr_ones, ld_min_tens, ld_min_ones}, 32'd0);
    chk("pending_loads", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/clock_set_controller.md
Name: clock_set_controller

Overview:
- Control/sequencing block for the digitalclock counter datapath.
- Generates the once-per-second count enable and runs a button-driven time-set state machine.
- Shadows hours and minutes while the user edits them, then loads them into the counter in one cycle.
- Drives blink-blanking flags for the display digits being edited.

Parameters:
TICK_DIV, 10, clk cycles per 1-second tick_en pulse (10 for sim; board value set at instantiation)
BLINK_DIV, 5, clk cycles per blink phase toggle in set states
REPEAT_DLY, 8, clk cycles btn_inc must be held before auto-repeat, and the auto-repeat period

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
btn_mode  in  1  mode button, level, already synchronised/debounced
btn_inc  in  1  increment button, level, already synchronised/debounced
cur_hr_tens, cur_hr_ones, cur_min_tens, cur_min_ones  in  4 each  live BCD time from counter
tick_en  out  1  1-cycle count enable to counter
load  out  1  1-cycle parallel-load strobe; counter loads ld_* and clears seconds to 00
ld_hr_tens, ld_hr_ones, ld_min_tens, ld_min_ones  out  4 each  BCD load value, valid when load=1
blank_hr, blank_min  out  1 each  display blanking for blink
mode  out  2  current state encoding

Behaviour:
- Reset (rst=0, async):
  - state RUN, prescaler 0, blink counter/phase 0, shadows 00:00.
  - tick_en=0, load=0, blank_*=0, ld_*=0.
  - Button-history registers cleared to 0.
- States and encodings: RUN=0, SET_HR=1, SET_MIN=2, COMMIT=3. All outputs are registered.
- Mode event: btn_mode rising edge (prev=0, cur=1). Mode has no auto-repeat. A button already held when reset releases produces an event only after it returns to 0 and rises again.
- Inc event:
  - btn_inc rising edge, or
  - while held continuously, one event after REPEAT_DLY cycles held and one every REPEAT_DLY cycles thereafter.
  - Release resets the hold counter.
- RUN:
  - Prescaler counts 0..TICK_DIV-1. tick_en=1 for exactly the cycle after the prescaler reaches TICK_DIV-1; the prescaler then wraps to 0.
  - Mode event: capture cur_hr_* and cur_min_* into the shadows, next state SET_HR, prescaler forced to 0.
  - Inc events are ignored.
- SET_HR:
  - tick_en held 0.
  - Inc event increments the shadow hour in BCD: 00..09, 10..19, 20..23, then 23 wraps to 00.
  - Mode event goes to SET_MIN.
- SET_MIN:
  - tick_en held 0.
  - Inc event increments the shadow minute in BCD: ones 0..9 with carry into tens; 59 wraps to 00; no carry into hours.
  - Mode event goes to COMMIT.
- COMMIT:
  - Single cycle: load=1, ld_* = shadows. Next state RUN with prescaler 0, so the first tick_en comes TICK_DIV cycles after load.
  - Buttons ignored. Edge history still updates, so no event is lost or invented.
- Latency: every button event changes state or shadow on the next clock edge. Outputs reflect the change one cycle after the event cycle.
- Simultaneous mode and inc event in the same cycle: mode wins and the inc is discarded.
- Blink:
  - Blink counter and phase clear on entry to SET_HR/SET_MIN.
  - Phase toggles every BLINK_DIV cycles.
  - blank_hr = (state==SET_HR) & phase; blank_min = (state==SET_MIN) & phase.
  - An inc event clears the counter and phase so edited digits stay visible.
  - Outside the set states, both blank outputs are 0.
- Reset mid-set: shadows are discarded, no load is issued, and the state returns to RUN.
- ld_* hold their last loaded value outside COMMIT.

Decomposition:
- Package clock_pkg:
  - State enum and its 2-bit encodings.
  - BCD limit constants: HR_MAX_TENS=2, HR_MAX_ONES_AT_2=3, MIN_MAX_TENS=5, BCD_MAX=9.
- Sub-module btn_event:
  - Edge detect plus optional auto-repeat, parameter REPEAT_EN.
  - Instantiated twice: btn_mode with REPEAT_EN=0, btn_inc with REPEAT_EN=1.

Test Plan:
- Reset, then run 50 cycles in RUN: tick_en pulses exactly every 10 cycles, with the first pulse 10 cycles after rst deasserts; load=0, mode=0.
- cur=12:34, mode pulse: mode=1, shadow 12. Three inc pulses give 15. Mode, mode: mode=2 then COMMIT emits load=1 for one cycle with ld=15:34; the next tick_en comes 10 cycles later.
- In SET_HR with shadow 23: one inc gives 00. In SET_MIN with 59: one inc gives 00 and the hour is unchanged. 09→10 and 19→20 carries are correct.
- Hold btn_inc 30 cycles in SET_MIN starting at 00: events at hold cycles 1, 8, 16, 24, giving 04; no tick_en during the hold.
- btn_mode and btn_inc rise in the same cycle in SET_HR: state goes to SET_MIN and the hour is unchanged. blank_hr toggles every 5 cycles in SET_HR and blank_min stays 0.
- Assert rst low in SET_MIN mid-edit: outputs clear immediately (async). After release: mode=0, no load pulse, tick_en resumes at 10 cycles.
